// File: rtl/shift_pkg.sv
// Shared definitions for the shift arbiter slice: FSM encoding and width helper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package shift_pkg;

    // Sequencer states. Encoding is fixed so that debug views and any
    // downstream decode of the state register stay stable.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        RESP  = 2'd2
    } state_t;

    // Ceiling log2 for sizing index fields. Returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/barrelShifter.sv
// Combinational rotate-left of an nBits operand by a nShifts-bit amount.
// Latency: zero cycles (pure combinational).
// Backpressure: none; output follows inputs.
//
// Ports:
//   in    operand
//   shift rotate amount (0 .. nBits-1)
//   out   in rotated left by shift
module barrelShifter #(
    parameter int nBits   = 8,
    parameter int nShifts = 3
) (
    input  logic [nBits-1:0]   in,
    input  logic [nShifts-1:0] shift,
    output logic [nBits-1:0]   out
);

    // Log-depth structure: stage k rotates by 2^k when shift[k] is set.
    // With nBits = 2^nShifts every stage amount is strictly below nBits,
    // so the right shift never degenerates.
    always_comb begin
        logic [nBits-1:0] v;
        v = in;
        for (int k = 0; k < nShifts; k++) begin
            if (shift[k]) begin
                v = (v << (1 << k)) | (v >> (nBits - (1 << k)));
            end
        end
        out = v;
    end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after rr_ptr.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the caller decides whether the grant is consumed.
//
// Ports:
//   req       request vector
//   rr_ptr    index where the priority scan starts (wraps modulo NREQ)
//   grant     one-hot grant, all-zero when no request
//   winner    encoded index of the granted request
//   any_valid at least one request asserted
module rr_arbiter
    import shift_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  rr_ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  winner,
    output logic            any_valid
);

    always_comb begin
        logic [IDW-1:0] idx;
        grant     = '0;
        winner    = '0;
        any_valid = 1'b0;
        idx       = '0;
        // Scan offsets from the pointer; the first hit wins and later hits
        // are ignored because any_valid is already set.
        for (int off = 0; off < NREQ; off++) begin
            idx = IDW'((int'(rr_ptr) + off) % NREQ);
            if (!any_valid && req[idx]) begin
                any_valid   = 1'b1;
                grant[idx]  = 1'b1;
                winner      = idx;
            end
        end
    end

endmodule

// File: rtl/shift_arbiter.sv
// Shares one barrelShifter among NREQ requesters with round-robin grant and a tagged response port.
// Latency: accept at edge N -> rsp_valid in cycle N+2; at least 3 cycles per operation.
// Backpressure: RESP holds result until rsp_ready; req_ready stays low outside IDLE.
//
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   req_valid/req_ready  per-requester handshake (req_ready at most one-hot)
//   req_data/req_shift   packed per-requester operand and rotate amount
//   rsp_valid/rsp_ready  response handshake
//   rsp_data/rsp_id      rotated result and index of the requester that owns it
//   busy                 sequencer is not in IDLE
module shift_arbiter
    import shift_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int nBits   = 8,
    parameter int nShifts = 3,
    parameter int IDW     = clog2(NREQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*nBits-1:0]     req_data,
    input  logic [NREQ*nShifts-1:0]   req_shift,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [nBits-1:0]          rsp_data,
    output logic [IDW-1:0]            rsp_id,
    output logic                      busy
);

    state_t             state_q;
    state_t             state_d;

    logic [IDW-1:0]     rr_ptr;
    logic [IDW-1:0]     ptr_next;

    logic [NREQ-1:0]    grant;
    logic [IDW-1:0]     winner;
    logic               any_valid;

    logic [nBits-1:0]   sel_data;
    logic [nShifts-1:0] sel_shift;

    logic [nBits-1:0]   op_data;
    logic [nShifts-1:0] op_shift;
    logic [IDW-1:0]     op_id;

    logic [nBits-1:0]   shift_out;

    logic               accept;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_arbiter (
        .req       (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .winner    (winner),
        .any_valid (any_valid)
    );

    barrelShifter #(
        .nBits   (nBits),
        .nShifts (nShifts)
    ) u_barrel_shifter (
        .in    (op_data),
        .shift (op_shift),
        .out   (shift_out)
    );

    // Winner's payload, picked straight off the packed request buses.
    assign sel_data  = req_data[int'(winner)*nBits +: nBits];
    assign sel_shift = req_shift[int'(winner)*nShifts +: nShifts];

    // The winner is always a valid requester, so a grant in IDLE is a
    // completed transfer.
    assign accept = (state_q == IDLE) && any_valid;

    // Pointer moves to the slot after the winner, wrapping at NREQ (which
    // need not be a power of two).
    assign ptr_next = (winner == IDW'(NREQ - 1)) ? '0 : winner + IDW'(1);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_valid) state_d = SHIFT;
            SHIFT:   state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    // req_ready is masked by rst so no requester sees a handshake on an
    // edge where the reset discards it anyway.
    always_comb begin
        req_ready = '0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (!rst) req_ready = grant;
            end
            SHIFT: begin
                rsp_valid = 1'b0;
            end
            RESP: begin
                rsp_valid = 1'b1;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Operand, pointer and response registers
    // ------------------------------------------------------------------
    // rsp_data/rsp_id are only loaded at the SHIFT edge, so they remain
    // stable through any length of RESP backpressure and keep the last
    // result visible while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr   <= '0;
            op_data  <= '0;
            op_shift <= '0;
            op_id    <= '0;
            rsp_data <= '0;
            rsp_id   <= '0;
        end else begin
            if (accept) begin
                op_data  <= sel_data;
                op_shift <= sel_shift;
                op_id    <= winner;
                rr_ptr   <= ptr_next;
            end
            if (state_q == SHIFT) begin
                rsp_data <= shift_out;
                rsp_id   <= op_id;
            end
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: transaction-level model plus directed literal pins.
// Latency: n/a (testbench).
// Backpressure: randomized rsp_ready, plus a directed 10-cycle stall.
module tb_shift_arbiter;

    localparam int NREQ = 4;
    localparam int NB   = 8;
    localparam int NS   = 3;
    localparam int IDW  = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*NB-1:0]   req_data  = '0;
    logic [NREQ*NS-1:0]   req_shift = '0;
    logic                 rsp_valid;
    logic                 rsp_ready = 1'b0;
    logic [NB-1:0]        rsp_data;
    logic [IDW-1:0]       rsp_id;
    logic                 busy;

    always #5 clk = ~clk;

    shift_arbiter #(
        .NREQ    (NREQ),
        .nBits   (NB),
        .nShifts (NS),
        .IDW     (IDW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_shift (req_shift),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    // Counters, owned by the compare process.
    int errors = 0;
    int checks = 0;

    // Controls written by the stimulus process only.
    bit          cmp_on     = 1'b0;
    bit          done       = 1'b0;
    bit          lit_rsp_on = 1'b0;
    logic [NB-1:0] lit_data = '0;
    int          lit_id     = 0;
    bit          lit_bp     = 1'b0;
    bit          no_rsp     = 1'b0;
    bit          lit_g_on   = 1'b0;
    bit          lit_gap    = 1'b0;
    int          lit_g [5];
    int          lit_gn     = 0;
    int          to_cnt     = 0;

    // Observations made by the stimulus process.
    logic [NREQ-1:0] acc;
    bit              hs;
    bit              rv;

    // Transaction-level model state (compare process only).
    bit          m_fly    = 1'b0;  // an accepted operation not yet answered
    int          m_age    = 0;     // cycles since its acceptance edge
    logic [NB-1:0] m_exp  = '0;
    int          m_id     = 0;
    logic [NB-1:0] m_last = '0;    // value rsp_data must show
    int          m_lastid = 0;
    int          m_ptr    = 0;
    bit          rst_q    = 1'b1;
    bit          prev_rv  = 1'b0;
    int          cyc      = 0;
    int          gcyc     = 0;
    int          lastg    = 0;
    int          lit_gi   = 0;
    int          n_rsp    = 0;
    bit          fin      = 1'b0;

    function automatic logic [NB-1:0] rotl(input logic [NB-1:0] x, input int s);
        int v;
        v = (int'(x) << s) | (int'(x) >> (NB - s));
        return v[NB-1:0];
    endfunction

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
        for (int off = 0; off < NREQ; off++) begin
            if (v[(p + off) % NREQ]) return (p + off) % NREQ;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Compare process: checks every cycle, then advances the model across
    // the coming rising edge.
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        logic [NREQ-1:0] exp_rdy;
        logic [NREQ-1:0] gvec;
        int w;
        int gw;
        cyc++;
        w = rr_pick(req_valid, m_ptr);
        exp_rdy = '0;
        if (!m_fly && !rst && w >= 0) exp_rdy[w] = 1'b1;
        gvec = req_valid & req_ready;
        gw = -1;
        for (int i = 0; i < NREQ; i++) if (gvec[i]) gw = i;

        if (cmp_on) begin
            chk("req_ready", int'(req_ready), int'(exp_rdy));
            chk("rsp_valid", int'(rsp_valid), (m_fly && m_age >= 2) ? 1 : 0);
            chk("busy", int'(busy), m_fly ? 1 : 0);
            chk("rsp_data", int'(rsp_data), int'(m_last));
            chk("rsp_id", int'(rsp_id), m_lastid);
            if (rst_q) begin
                chk("rst_rsp_valid", int'(rsp_valid), 0);
                chk("rst_busy", int'(busy), 0);
                chk("rst_rsp_data", int'(rsp_data), 0);
                chk("rst_rsp_id", int'(rsp_id), 0);
                if (rst) chk("rst_req_ready", int'(req_ready), 0);
            end
            if (rsp_valid && !prev_rv) chk("latency", cyc - gcyc, 2);
            if (lit_rsp_on && rsp_valid && rsp_ready) begin
                chk("lit_rsp_data", int'(rsp_data), int'(lit_data));
                chk("lit_rsp_id", int'(rsp_id), lit_id);
            end
            if (lit_bp) begin
                chk("bp_req_ready", int'(req_ready), 0);
                chk("bp_rsp_valid", int'(rsp_valid), 1);
                chk("bp_busy", int'(busy), 1);
            end
            if (no_rsp) chk("dropped_rsp", int'(rsp_valid), 0);
            if (!lit_g_on) begin
                lit_gi = 0;
            end else if (gw >= 0 && lit_gi < lit_gn) begin
                chk("grant_order", gw, lit_g[lit_gi]);
                chk("grant_onehot", $countones(req_ready), 1);
                if (lit_gap && lit_gi > 0) chk("grant_gap", cyc - lastg, 3);
                lit_gi++;
            end
            if (done && !fin) begin
                chk("timeouts", to_cnt, 0);
                chk("responses_seen", (n_rsp >= 20) ? 1 : 0, 1);
                fin = 1'b1;
            end
        end

        if (gw >= 0) begin
            gcyc  = cyc;
            lastg = cyc;
        end
        if (rsp_valid && rsp_ready) n_rsp++;
        prev_rv = rsp_valid;
        rst_q   = rst;

        // Model advance for the upcoming edge.
        if (rst) begin
            m_fly    = 1'b0;
            m_age    = 0;
            m_ptr    = 0;
            m_last   = '0;
            m_lastid = 0;
        end else if (!m_fly) begin
            if (w >= 0) begin
                m_fly = 1'b1;
                m_age = 1;
                m_exp = rotl(req_data[w*NB +: NB], int'(req_shift[w*NS +: NS]));
                m_id  = w;
                m_ptr = (w + 1) % NREQ;
            end
        end else if (m_age == 1) begin
            m_age    = 2;
            m_last   = m_exp;
            m_lastid = m_id;
        end else if (rsp_ready) begin
            m_fly = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic step();
        @(negedge clk);
        acc = req_valid & req_ready;
        hs  = rsp_valid & rsp_ready;
        rv  = rsp_valid;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [NB-1:0] d, input logic [NS-1:0] s);
        req_data[i*NB +: NB]  = d;
        req_shift[i*NS +: NS] = s;
    endtask

    task automatic rand_payload(input int i);
        set_req(i, NB'($urandom), NS'($urandom));
    endtask

    task automatic wait_acc(input int i);
        for (int k = 0; k < 20; k++) begin
            step();
            if (acc[i]) return;
        end
        to_cnt++;
    endtask

    task automatic wait_hs();
        for (int k = 0; k < 30; k++) begin
            step();
            if (hs) return;
        end
        to_cnt++;
    endtask

    task automatic do_single(input int i, input logic [NB-1:0] d,
                             input logic [NS-1:0] s, input logic [NB-1:0] e);
        lit_data   = e;
        lit_id     = i;
        lit_rsp_on = 1'b1;
        set_req(i, d, s);
        req_valid  = '0;
        req_valid[i] = 1'b1;
        wait_acc(i);
        req_valid  = '0;
        wait_hs();
        lit_rsp_on = 1'b0;
        step();
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        // Reset with every requester valid, then fairness straight after.
        for (int i = 0; i < NREQ; i++) rand_payload(i);
        req_valid = '1;
        rsp_ready = 1'b1;
        lit_g[0] = 0; lit_g[1] = 1; lit_g[2] = 2; lit_g[3] = 3; lit_g[4] = 0;
        lit_gn   = 5;
        lit_g_on = 1'b1;
        lit_gap  = 1'b1;
        step();
        cmp_on = 1'b1;
        step();
        rst = 1'b0;
        for (int c = 0; c < 16; c++) begin
            step();
            for (int i = 0; i < NREQ; i++) if (acc[i]) rand_payload(i);
        end
        lit_g_on  = 1'b0;
        lit_gap   = 1'b0;
        req_valid = '0;
        repeat (4) step();

        // Single requests with hand-computed rotations.
        do_single(2, 8'b0000_0001, 3'd3, 8'b0000_1000);
        do_single(1, 8'b1000_0001, 3'd1, 8'b0000_0011);
        do_single(0, 8'hA5,        3'd0, 8'hA5);
        do_single(3, 8'h01,        3'd7, 8'h80);

        // Backpressure: stall RESP, others waiting, then release.
        rsp_ready  = 1'b0;
        lit_data   = 8'hF0;
        lit_id     = 1;
        lit_rsp_on = 1'b1;
        set_req(1, 8'h3C, 3'd2);
        req_valid  = 4'b0010;
        wait_acc(1);
        rand_payload(0);
        rand_payload(3);
        req_valid = 4'b1001;
        rv = 1'b0;
        for (int k = 0; k < 10 && !rv; k++) step();
        lit_bp = 1'b1;
        repeat (10) step();
        lit_g[0] = 3; lit_g[1] = 0;
        lit_gn   = 2;
        lit_g_on = 1'b1;
        rsp_ready = 1'b1;
        wait_hs();
        lit_bp     = 1'b0;
        lit_rsp_on = 1'b0;
        // Pointer wrap: 3 wins now, then 0 ahead of a re-presented 3.
        wait_acc(3);
        rand_payload(3);
        wait_hs();
        wait_acc(0);
        req_valid = '0;
        wait_hs();
        lit_g_on = 1'b0;
        step();

        // Reset during SHIFT: response dropped, pointer back to 0.
        set_req(2, 8'h55, 3'd1);
        req_valid = 4'b0100;
        wait_acc(2);
        rst       = 1'b1;
        no_rsp    = 1'b1;
        req_valid = '0;
        step();
        rst = 1'b0;
        step();
        step();
        no_rsp = 1'b0;
        lit_g[0] = 1;
        lit_gn   = 1;
        lit_g_on = 1'b1;
        rand_payload(1);
        rand_payload(3);
        req_valid = 4'b1010;
        wait_acc(1);
        req_valid = '0;
        wait_hs();
        lit_g_on = 1'b0;
        step();

        // Randomized traffic with drop-outs, stalls and occasional reset.
        for (int c = 0; c < 3000; c++) begin
            step();
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i] || !req_valid[i]) begin
                    if ($urandom_range(0, 99) < 40) begin
                        req_valid[i] = 1'b1;
                        rand_payload(i);
                    end else begin
                        req_valid[i] = 1'b0;
                    end
                end else if ($urandom_range(0, 99) < 3) begin
                    req_valid[i] = 1'b0;
                end
            end
            rsp_ready = ($urandom_range(0, 99) < 60);
            rst       = ($urandom_range(0, 299) == 0);
        end
        rst       = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (5) step();

        done = 1'b1;
        step();
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
